// File: rtl/mod_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_delay_line_if
//  Purpose  : Sample-stream bundle between a dry source and mod_delay_line.
//             master = sample source / wet consumer, slave = delay line.
//  Revision : 1.0  initial release
// ============================================================================
interface mod_delay_line_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] pktDry_i;
  logic                    pktValid_i;
  logic signed [WIDTH-1:0] pktWet_o;
  logic                    pktValid_o;
  logic                    busy_o;

  modport master (
    output pktDry_i,
    output pktValid_i,
    input  pktWet_o,
    input  pktValid_o,
    input  busy_o
  );

  modport slave (
    input  pktDry_i,
    input  pktValid_i,
    output pktWet_o,
    output pktValid_o,
    output busy_o
  );
endinterface
`default_nettype wire

// File: rtl/mod_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : mod_delay_line
//  Purpose  : Triangle-LFO modulated circular-buffer delay (chorus/flanger
//             wet path). Each accepted dry sample is written into a RAM ring
//             and one sample is read back BASE_DELAY+lfo positions earlier.
//  Options  : WET_FEEDBACK_EN - when defined, half of the previous wet output
//             is added (with signed saturation) to the dry sample before it
//             is written into the ring.
//  Revision : 1.0  initial release
// ============================================================================
module mod_delay_line #(
  parameter int WIDTH        = 16,
  parameter int DEPTH_LOG2   = 10,
  parameter int BASE_DELAY   = 256,
  parameter int MOD_DEPTH    = 128,
  parameter int LFO_STEP_DIV = 64
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  mod_delay_line_if.slave   bus
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = (LFO_STEP_DIV > 1) ? $clog2(LFO_STEP_DIV) : 1;

  localparam logic        [AW-1:0] c_FILL_MAX = '1;
  localparam logic        [AW:0]   c_BASE     = (AW+1)'(BASE_DELAY);
  localparam logic signed [AW:0]   c_MOD_POS  = (AW+1)'(MOD_DEPTH);
  localparam logic signed [AW:0]   c_MOD_NEG  = -((AW+1)'(MOD_DEPTH));
  localparam logic        [DW-1:0] c_DIV_LAST = DW'(LFO_STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  logic signed [WIDTH-1:0] r_ram [DEPTH];

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_dry;
  logic        [AW-1:0]    r_wr_ptr;
  logic        [AW-1:0]    r_rd_addr;
  logic        [AW-1:0]    r_fill_cnt;
  logic                    r_gate;
  logic signed [AW:0]      r_lfo;
  logic                    r_lfo_down;
  logic        [DW-1:0]    r_div_cnt;
  logic signed [WIDTH-1:0] r_wet;
  logic                    r_valid_o;
  logic                    r_busy;

  logic        [AW:0]      w_delay;
  logic signed [AW:0]      w_lfo_up;
  logic signed [AW:0]      w_lfo_dn;
  logic signed [WIDTH-1:0] w_wr_data;

  // Current read-back distance and the two candidate LFO successors
  always_comb begin
    w_delay  = c_BASE + $unsigned(r_lfo);
    w_lfo_up = r_lfo + (AW+1)'(1);
    w_lfo_dn = r_lfo - (AW+1)'(1);
  end

`ifdef WET_FEEDBACK_EN
  logic signed [WIDTH-1:0] r_fb;
  logic signed [WIDTH:0]   w_sum;

  // Dry plus half the previous wet, clamped to the signed sample range
  always_comb begin
    w_sum = $signed({r_dry[WIDTH-1], r_dry})
          + $signed({r_fb[WIDTH-1], r_fb[WIDTH-1], r_fb[WIDTH-1:1]});
    if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
      w_wr_data = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_wr_data = w_sum[WIDTH-1:0];
    end
  end

  // Feedback register captures each wet value as it is presented
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fb <= '0;
    end else if (r_state == S_OUT) begin
      r_fb <= r_wet;
    end
  end
`else
  // Without feedback the ring stores the dry sample unchanged
  always_comb begin
    w_wr_data = r_dry;
  end
`endif

  // Ring storage: written only in WRITE, so reads never collide with writes
  always_ff @(posedge clk_i) begin
    if (r_state == S_WRITE) begin
      r_ram[r_wr_ptr] <= w_wr_data;
    end
  end

  // Sequencer: IDLE -> WRITE -> READ -> OUT, with registered outputs and LFO
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_dry      <= '0;
      r_wr_ptr   <= '0;
      r_rd_addr  <= '0;
      r_fill_cnt <= '0;
      r_gate     <= 1'b0;
      r_lfo      <= '0;
      r_lfo_down <= 1'b0;
      r_div_cnt  <= '0;
      r_wet      <= '0;
      r_valid_o  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pktValid_i) begin
            r_dry   <= bus.pktDry_i;
            r_busy  <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Fill count gates reads so stale RAM contents never reach the output
          r_rd_addr <= r_wr_ptr - w_delay[AW-1:0];
          r_gate    <= ({1'b0, r_fill_cnt} >= w_delay);
          r_wr_ptr  <= r_wr_ptr + AW'(1);
          if (r_fill_cnt != c_FILL_MAX) begin
            r_fill_cnt <= r_fill_cnt + AW'(1);
          end
          r_state <= S_READ;
        end
        S_READ: begin
          // Synchronous read lands directly in the output register so the
          // wet value and its strobe appear together in OUT
          r_wet     <= r_gate ? r_ram[r_rd_addr] : '0;
          r_valid_o <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          r_valid_o <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            if (MOD_DEPTH != 0) begin
              if (r_lfo_down) begin
                r_lfo <= w_lfo_dn;
                if (w_lfo_dn == c_MOD_NEG) r_lfo_down <= 1'b0;
              end else begin
                r_lfo <= w_lfo_up;
                if (w_lfo_up == c_MOD_POS) r_lfo_down <= 1'b1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pktWet_o   = r_wet;
  assign bus.pktValid_o = r_valid_o;
  assign bus.busy_o     = r_busy;

endmodule
`default_nettype wire
